// File: rtl/mdu_sched_pkg.sv
// mdu_sched_pkg: MDU op codes, FSM states and default latencies
package mdu_sched_pkg;
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  function automatic logic is_muldiv(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  endfunction
endpackage

// File: rtl/mdu_sched_arith.sv
// mdu_arith: combinational HI/LO result for mult/multu/div/divu
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);
  logic               w_dz, w_ovf;
  logic        [63:0] w_prod_s, w_prod_u;
  logic signed [31:0] w_sa, w_sb, w_sq, w_sr;
  logic        [31:0] w_ub, w_uq, w_ur;
  assign w_dz = rt_val == '0;
  assign w_ovf = rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF;
  assign w_prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign w_prod_u = {32'b0, rs_val} * {32'b0, rt_val};
  // Dividing the overflow case by 1 yields exactly 0x80000000 rem 0
  assign w_sa = rs_val;
  assign w_sb = (w_dz || w_ovf) ? 32'sd1 : $signed(rt_val);
  assign w_sq = w_sa / w_sb;
  assign w_sr = w_sa % w_sb;
  assign w_ub = w_dz ? 32'd1 : rt_val;
  assign w_uq = rs_val / w_ub;
  assign w_ur = rs_val % w_ub;
  assign div_zero = w_dz && (op == MDU_DIV || op == MDU_DIVU);
  always_comb begin
    res_hi = op == MDU_MULT ? w_prod_s[63:32] : op == MDU_MULTU ? w_prod_u[63:32] :
             op == MDU_DIV ? w_sr : op == MDU_DIVU ? w_ur : '0;
    res_lo = op == MDU_MULT ? w_prod_s[31:0] : op == MDU_MULTU ? w_prod_u[31:0] :
             op == MDU_DIV ? w_sq : op == MDU_DIVU ? w_uq : '0;
  end
endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: E-stage MDU scheduler owning HI/LO, busy window and D-stage stall
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] mf_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
  state_e          r_state, w_next_state;
  logic [CW-1:0]   r_count, w_next_count;
  logic [31:0]     r_hi, r_lo, r_res_hi, r_res_lo, w_res_hi, w_res_lo;
  logic            r_dz, w_dz, w_md, w_issue, w_done, w_idle_start;
  mdu_arith u_arith (
    .op       (mdu_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_dz)
  );
  assign w_md = is_muldiv(mdu_op);
  assign w_idle_start = start && r_state == IDLE;
  assign w_issue = w_idle_start && w_md;
  assign w_done = r_state == RUN && r_count == CW'(1);
  always_comb begin
    w_next_state = w_issue ? RUN : w_done ? IDLE : r_state;
    w_next_count = w_issue ? ((mdu_op == MDU_MULT || mdu_op == MDU_MULTU) ? CW'(MULT_LAT) : CW'(DIV_LAT)) :
                   r_state == RUN ? r_count - CW'(1) : r_count;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_next_count;
    end
  end
  // Result is captured at issue so operands need not stay stable during RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_issue) begin
        r_res_hi <= w_res_hi;
        r_res_lo <= w_res_lo;
        r_dz     <= w_dz;
      end
      if (w_done && !r_dz) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end else if (w_idle_start && mdu_op == MDU_MTHI) begin
        r_hi <= rs_val;
      end else if (w_idle_start && mdu_op == MDU_MTLO) begin
        r_lo <= rs_val;
      end
    end
  end
  assign busy = r_state == RUN;
  assign stall_req = d_md_use && (busy || (start && w_md));
  assign mf_out = mdu_op == MDU_MFHI ? r_hi : mdu_op == MDU_MFLO ? r_lo : '0;
  assign hi = r_hi;
  assign lo = r_lo;
endmodule
